// File: rtl/bus_pkg.sv
// Shared encodings and default widths for the bus arbiter slice.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int DEF_N_MASTERS = 3;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TIMEOUT   = 15;
    localparam int DEF_HOLD_MAX  = 31;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side requests, external bus and lock signals of the arbiter.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    logic [N_MASTERS-1:0]        i_req;
    logic [N_MASTERS-1:0]        i_rw;
    logic [N_MASTERS-1:0]        i_lock_req;
    logic [N_MASTERS*ADDR_W-1:0] i_addr;
    logic [N_MASTERS*DATA_W-1:0] i_wdata;
    logic [N_MASTERS-1:0]        o_gnt;
    logic [N_MASTERS-1:0]        o_done;
    logic [N_MASTERS-1:0]        o_err;
    logic [DATA_W-1:0]           o_rdata;
    logic                        o_bus_valid;
    logic                        o_bus_rw;
    logic [ADDR_W-1:0]           o_bus_addr;
    logic [DATA_W-1:0]           o_bus_wdata;
    logic [DATA_W-1:0]           i_bus_rdata;
    logic                        i_bus_ready;
    logic                        i_ext_lock;
    logic                        o_ext_lock;

    // Environment side: masters plus the external bus target.
    modport master (
        output i_req, i_rw, i_lock_req, i_addr, i_wdata,
        output i_bus_rdata, i_bus_ready, i_ext_lock,
        input  o_gnt, o_done, o_err, o_rdata,
        input  o_bus_valid, o_bus_rw, o_bus_addr, o_bus_wdata, o_ext_lock
    );

    modport slave (
        input  i_req, i_rw, i_lock_req, i_addr, i_wdata,
        input  i_bus_rdata, i_bus_ready, i_ext_lock,
        output o_gnt, o_done, o_err, o_rdata,
        output o_bus_valid, o_bus_rw, o_bus_addr, o_bus_wdata, o_ext_lock
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
)(
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand_s;

    // Scan candidates ptr+1 .. ptr+N; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int off = 1; off <= N; off++) begin
            cand_s = IDX_W'((int'(ptr_i) + off) % N);
            if (!valid_o && req_i[cand_s]) begin
                valid_o       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-access timeout and master lock (HOLD) support.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int HOLD_MAX  = DEF_HOLD_MAX
)(
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    localparam int IDX_W  = $clog2(N_MASTERS);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int HCNT_W = $clog2(HOLD_MAX + 1);

    state_e                state_q, state_d;
    logic [N_MASTERS-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [N_MASTERS-1:0]  done_q, done_d;
    logic [N_MASTERS-1:0]  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
    logic                  ext_lock_q, ext_lock_d;
    logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
    logic [HCNT_W-1:0]     hcnt_q, hcnt_d;

    logic [N_MASTERS-1:0]  eligible_s;
    logic [N_MASTERS-1:0]  pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_valid_s;
    logic [ADDR_W-1:0]     addr_s  [N_MASTERS];
    logic [DATA_W-1:0]     wdata_s [N_MASTERS];

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
        assign addr_s[g]  = bus.i_addr[g*ADDR_W +: ADDR_W];
        assign wdata_s[g] = bus.i_wdata[g*DATA_W +: DATA_W];
    end

    // A master whose done pulse is visible this cycle must not win again.
    assign eligible_s = bus.i_req & ~done_q;

    rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req_i   (eligible_s),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Next-state and registered-output logic for IDLE / ACCESS / HOLD.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        win_d       = win_q;
        ptr_d       = ptr_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        bus_valid_d = bus_valid_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        ext_lock_d  = ext_lock_q;
        tcnt_d      = tcnt_q;
        hcnt_d      = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                hcnt_d = '0;
                if (!bus.i_ext_lock && pick_valid_s) begin
                    state_d     = ST_ACCESS;
                    gnt_d       = pick_gnt_s;
                    win_d       = pick_idx_s;
                    bus_valid_d = 1'b1;
                    bus_rw_d    = bus.i_rw[pick_idx_s];
                    bus_addr_d  = addr_s[pick_idx_s];
                    bus_wdata_d = wdata_s[pick_idx_s];
                    ext_lock_d  = 1'b0;
                end else begin
                    gnt_d       = '0;
                    bus_valid_d = 1'b0;
                    bus_rw_d    = 1'b0;
                    ext_lock_d  = 1'b0;
                end
            end
            ST_ACCESS: begin
                // Ready in the final counted cycle still wins over the timeout.
                if (bus.i_bus_ready) begin
                    done_d[win_q] = 1'b1;
                    rdata_d       = bus_rw_q ? rdata_q : bus.i_bus_rdata;
                    ptr_d         = win_q;
                    bus_valid_d   = 1'b0;
                    bus_rw_d      = 1'b0;
                    tcnt_d        = '0;
                    hcnt_d        = '0;
                    if (bus.i_lock_req[win_q]) begin
                        state_d    = ST_HOLD;
                        ext_lock_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        ext_lock_d = 1'b0;
                    end
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    done_d[win_q] = 1'b1;
                    err_d[win_q]  = 1'b1;
                    state_d       = ST_IDLE;
                    gnt_d         = '0;
                    bus_valid_d   = 1'b0;
                    bus_rw_d      = 1'b0;
                    ext_lock_d    = 1'b0;
                    tcnt_d        = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!bus.i_lock_req[win_q] || (hcnt_q == HCNT_W'(HOLD_MAX - 1))) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    ext_lock_d = 1'b0;
                    hcnt_d     = '0;
                end else if (bus.i_req[win_q] && !done_q[win_q]) begin
                    state_d     = ST_ACCESS;
                    bus_valid_d = 1'b1;
                    bus_rw_d    = bus.i_rw[win_q];
                    bus_addr_d  = addr_s[win_q];
                    bus_wdata_d = wdata_s[win_q];
                    tcnt_d      = '0;
                    hcnt_d      = '0;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                bus_valid_d = 1'b0;
                bus_rw_d    = 1'b0;
                ext_lock_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            win_q       <= '0;
            ptr_q       <= IDX_W'(N_MASTERS - 1);
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            ext_lock_q  <= 1'b0;
            tcnt_q      <= '0;
            hcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_valid_q <= bus_valid_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            ext_lock_q  <= ext_lock_d;
            tcnt_q      <= tcnt_d;
            hcnt_q      <= hcnt_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_bus_valid = bus_valid_q;
    assign bus.o_bus_rw    = bus_rw_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_wdata = bus_wdata_q;
    assign bus.o_ext_lock  = ext_lock_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: directed table/sequences plus random traffic against a transaction-level model.
module tb_bus_arbiter;

    localparam int N        = 3;
    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int TIMEOUT  = 15;
    localparam int HOLD_MAX = 31;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] req;
        logic       ready;
        logic [2:0] gnt;
        logic [2:0] done;
        logic       valid;
    } vec_t;

    vec_t tbl [12];

    // Random-phase stimulus and model state.
    logic [AW-1:0] s_addr  [N];
    logic [DW-1:0] s_wdata [N];
    logic [2:0]    s_rw, s_lock, s_want;
    bit            m_busy, m_held;
    int            m_age, m_hold_age, m_ptr;
    logic [1:0]    m_owner;
    logic [2:0]    e_gnt, e_done, e_err;
    logic [DW-1:0] e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    logic          e_valid, e_rw, e_lock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.i_req       = '0;
        bif.i_rw        = '0;
        bif.i_lock_req  = '0;
        bif.i_addr      = '0;
        bif.i_wdata     = '0;
        bif.i_bus_rdata = '0;
        bif.i_bus_ready = 1'b0;
        bif.i_ext_lock  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},   bif.o_gnt, 0);
        chk({tag, ".done"},  bif.o_done, 0);
        chk({tag, ".err"},   bif.o_err, 0);
        chk({tag, ".rdata"}, bif.o_rdata, 0);
        chk({tag, ".valid"}, bif.o_bus_valid, 0);
        chk({tag, ".rw"},    bif.o_bus_rw, 0);
        chk({tag, ".addr"},  bif.o_bus_addr, 0);
        chk({tag, ".wdata"}, bif.o_bus_wdata, 0);
        chk({tag, ".lock"},  bif.o_ext_lock, 0);
    endtask

    task automatic model_start(input logic [1:0] k);
        m_busy       = 1'b1;
        m_owner      = k;
        m_age        = 0;
        e_gnt        = '0;
        e_gnt[k]     = 1'b1;
        e_valid      = 1'b1;
        e_rw         = bif.i_rw[k];
        e_addr       = s_addr[k];
        e_wdata      = s_wdata[k];
    endtask

    // Transaction-level reference: one call per rising edge, inputs as seen at that edge.
    task automatic model_step();
        logic [2:0] nd, ne;
        logic [1:0] c;
        bit         found;
        nd = '0; ne = '0; found = 1'b0; c = '0;
        if (rst) begin
            m_busy = 1'b0; m_held = 1'b0; m_age = 0; m_hold_age = 0; m_ptr = N - 1; m_owner = '0;
            e_gnt = '0; e_rdata = '0; e_valid = 1'b0; e_rw = 1'b0;
            e_addr = '0; e_wdata = '0; e_lock = 1'b0;
        end else if (m_busy) begin
            m_age++;
            if (bif.i_bus_ready) begin
                nd[m_owner] = 1'b1;
                if (!e_rw) e_rdata = bif.i_bus_rdata;
                m_ptr = int'(m_owner); m_busy = 1'b0; e_valid = 1'b0; e_rw = 1'b0;
                if (bif.i_lock_req[m_owner]) begin
                    m_held = 1'b1; m_hold_age = 0; e_lock = 1'b1;
                end else begin
                    m_held = 1'b0; e_gnt = '0; e_lock = 1'b0;
                end
            end else if (m_age == TIMEOUT) begin
                nd[m_owner] = 1'b1; ne[m_owner] = 1'b1;
                m_busy = 1'b0; m_held = 1'b0; e_gnt = '0; e_valid = 1'b0; e_rw = 1'b0; e_lock = 1'b0;
            end
        end else if (m_held) begin
            m_hold_age++;
            if (!bif.i_lock_req[m_owner] || m_hold_age == HOLD_MAX) begin
                m_held = 1'b0; e_gnt = '0; e_lock = 1'b0;
            end else if (bif.i_req[m_owner] && !e_done[m_owner]) begin
                m_held = 1'b0;
                model_start(m_owner);
            end
        end else if (!bif.i_ext_lock) begin
            for (int s = 1; s <= N; s++) begin
                c = 2'((m_ptr + s) % N);
                if (!found && bif.i_req[c] && !e_done[c]) begin
                    found = 1'b1;
                    model_start(c);
                    e_lock = 1'b0;
                end
            end
        end
        e_done = nd;
        e_err  = ne;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();

        // Reset state.
        do_reset();
        chk_all_zero("reset");

        // Round-robin with all three requesting, ready on the 2nd ACCESS cycle.
        tbl[0]  = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1};
        tbl[1]  = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1};
        tbl[2]  = '{3'b111, 1'b1, 3'b000, 3'b001, 1'b0};
        tbl[3]  = '{3'b111, 1'b0, 3'b010, 3'b000, 1'b1};
        tbl[4]  = '{3'b111, 1'b0, 3'b010, 3'b000, 1'b1};
        tbl[5]  = '{3'b111, 1'b1, 3'b000, 3'b010, 1'b0};
        tbl[6]  = '{3'b111, 1'b0, 3'b100, 3'b000, 1'b1};
        tbl[7]  = '{3'b111, 1'b0, 3'b100, 3'b000, 1'b1};
        tbl[8]  = '{3'b111, 1'b1, 3'b000, 3'b100, 1'b0};
        tbl[9]  = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1};
        tbl[10] = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1};
        tbl[11] = '{3'b111, 1'b1, 3'b000, 3'b001, 1'b0};
        for (int i = 0; i < 12; i++) begin
            bif.i_req       = tbl[i].req;
            bif.i_bus_ready = tbl[i].ready;
            tick();
            chk($sformatf("rr[%0d].gnt", i),   bif.o_gnt,       tbl[i].gnt);
            chk($sformatf("rr[%0d].done", i),  bif.o_done,      tbl[i].done);
            chk($sformatf("rr[%0d].valid", i), bif.o_bus_valid, tbl[i].valid);
        end

        // Master 1 read, ready on 3rd ACCESS cycle, payload wiggled mid-access.
        do_reset();
        bif.i_req = 3'b010;
        bif.i_addr = {16'h0000, 16'h1234, 16'h0000};
        tick();
        chk("rd.gnt", bif.o_gnt, 3'b010);
        chk("rd.addr", bif.o_bus_addr, 16'h1234);
        chk("rd.rw", bif.o_bus_rw, 1'b0);
        bif.i_addr = {16'h0000, 16'h5555, 16'h0000};
        tick();
        chk("rd.addr_stable", bif.o_bus_addr, 16'h1234);
        tick();
        chk("rd.early_done", bif.o_done, 3'b000);
        bif.i_bus_ready = 1'b1;
        bif.i_bus_rdata = 16'hBEEF;
        tick();
        chk("rd.done", bif.o_done, 3'b010);
        chk("rd.err", bif.o_err, 3'b000);
        chk("rd.rdata", bif.o_rdata, 16'hBEEF);
        chk("rd.valid_off", bif.o_bus_valid, 1'b0);
        bif.i_req = '0;
        bif.i_bus_ready = 1'b0;
        bif.i_bus_rdata = 16'h0000;
        tick();
        chk("rd.done_pulse", bif.o_done, 3'b000);
        chk("rd.rdata_kept", bif.o_rdata, 16'hBEEF);

        // Timeout: ready never comes.
        do_reset();
        bif.i_req = 3'b001;
        tick();
        chk("to.gnt", bif.o_gnt, 3'b001);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) begin
                chk($sformatf("to.c%0d.done", k), bif.o_done, 3'b000);
                chk($sformatf("to.c%0d.gnt", k), bif.o_gnt, 3'b001);
            end else begin
                chk("to.done", bif.o_done, 3'b001);
                chk("to.err", bif.o_err, 3'b001);
                chk("to.gnt_off", bif.o_gnt, 3'b000);
                chk("to.valid_off", bif.o_bus_valid, 1'b0);
                chk("to.rdata", bif.o_rdata, 16'h0000);
            end
        end
        bif.i_req = '0;
        tick();
        chk("to.err_pulse", bif.o_err, 3'b000);
        bif.i_req = 3'b001;
        tick();
        chk("to.regrant", bif.o_gnt, 3'b001);

        // Lock: master 2 does two locked writes while master 0 waits.
        do_reset();
        bif.i_req = 3'b100; bif.i_lock_req = 3'b100; bif.i_rw = 3'b100;
        bif.i_addr = {16'hA000, 32'h0}; bif.i_wdata = {16'h1111, 32'h0};
        tick();
        chk("lk.gnt1", bif.o_gnt, 3'b100);
        chk("lk.wdata1", bif.o_bus_wdata, 16'h1111);
        chk("lk.rw1", bif.o_bus_rw, 1'b1);
        chk("lk.lock_first", bif.o_ext_lock, 1'b0);
        bif.i_req = 3'b101; bif.i_bus_ready = 1'b1;
        tick();
        chk("lk.done1", bif.o_done, 3'b100);
        chk("lk.hold_gnt", bif.o_gnt, 3'b100);
        chk("lk.hold_lock", bif.o_ext_lock, 1'b1);
        bif.i_req = 3'b001; bif.i_bus_ready = 1'b0;
        bif.i_addr = {16'hA002, 32'h0}; bif.i_wdata = {16'h2222, 32'h0};
        tick();
        chk("lk.hold2_gnt", bif.o_gnt, 3'b100);
        chk("lk.hold2_lock", bif.o_ext_lock, 1'b1);
        bif.i_req = 3'b101;
        tick();
        chk("lk.acc2_gnt", bif.o_gnt, 3'b100);
        chk("lk.acc2_addr", bif.o_bus_addr, 16'hA002);
        chk("lk.acc2_wdata", bif.o_bus_wdata, 16'h2222);
        chk("lk.acc2_lock", bif.o_ext_lock, 1'b1);
        bif.i_bus_ready = 1'b1;
        tick();
        chk("lk.done2", bif.o_done, 3'b100);
        chk("lk.done2_lock", bif.o_ext_lock, 1'b1);
        bif.i_req = 3'b001; bif.i_lock_req = 3'b000; bif.i_bus_ready = 1'b0;
        tick();
        chk("lk.release_gnt", bif.o_gnt, 3'b000);
        chk("lk.release_lock", bif.o_ext_lock, 1'b0);
        tick();
        chk("lk.m0_gnt", bif.o_gnt, 3'b001);

        // Forced release after HOLD_MAX idle HOLD cycles.
        do_reset();
        bif.i_req = 3'b010; bif.i_lock_req = 3'b010;
        tick();
        bif.i_bus_ready = 1'b1;
        tick();
        chk("hm.enter_lock", bif.o_ext_lock, 1'b1);
        bif.i_req = 3'b001; bif.i_bus_ready = 1'b0;
        for (int k = 1; k <= HOLD_MAX; k++) begin
            tick();
            if (k < HOLD_MAX) begin
                if (bif.o_ext_lock !== 1'b1 || bif.o_gnt !== 3'b010)
                    chk($sformatf("hm.c%0d.gnt_lock", k), {bif.o_gnt, bif.o_ext_lock}, {3'b010, 1'b1});
            end else begin
                chk("hm.release_gnt", bif.o_gnt, 3'b000);
                chk("hm.release_lock", bif.o_ext_lock, 1'b0);
            end
        end
        tick();
        chk("hm.m0_gnt", bif.o_gnt, 3'b001);

        // Foreign lock blocks grants in IDLE only.
        do_reset();
        bif.i_ext_lock = 1'b1; bif.i_req = 3'b001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("xl.c%0d.gnt", k), bif.o_gnt, 3'b000);
        end
        bif.i_ext_lock = 1'b0;
        tick();
        chk("xl.gnt", bif.o_gnt, 3'b001);

        // Reset in the middle of an access.
        do_reset();
        bif.i_req = 3'b010; bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 16'hCAFE;
        tick();
        tick();
        chk("mr.rdata", bif.o_rdata, 16'hCAFE);
        bif.i_req = 3'b100; bif.i_bus_ready = 1'b0;
        tick();
        chk("mr.gnt2", bif.o_gnt, 3'b100);
        tick();
        bif.i_req = 3'b111; rst = 1'b1;
        tick();
        chk_all_zero("mr");
        rst = 1'b0;
        tick();
        chk("mr.first_gnt", bif.o_gnt, 3'b001);

        // Random traffic against the reference model.
        clear_inputs();
        s_want = '0; s_rw = '0; s_lock = '0;
        for (int k = 0; k < N; k++) begin
            s_addr[k] = '0; s_wdata[k] = '0;
        end
        e_done = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (s_want[k] && bif.o_done[k]) begin
                    s_want[k] = 1'b0;
                end else if (!s_want[k] && $urandom_range(0, 3) == 0) begin
                    s_want[k]  = 1'b1;
                    s_rw[k]    = 1'($urandom_range(0, 1));
                    s_addr[k]  = 16'($urandom);
                    s_wdata[k] = 16'($urandom);
                end
                if ($urandom_range(0, 7) == 0) s_lock[k] = ~s_lock[k];
            end
            rst             = (cyc < 2) || ($urandom_range(0, 599) == 0);
            bif.i_req       = s_want;
            bif.i_rw        = s_rw;
            bif.i_lock_req  = s_lock;
            bif.i_addr      = {s_addr[2], s_addr[1], s_addr[0]};
            bif.i_wdata     = {s_wdata[2], s_wdata[1], s_wdata[0]};
            bif.i_bus_rdata = 16'($urandom);
            bif.i_bus_ready = ($urandom_range(0, 99) < (((cyc / 400) % 2 == 0) ? 40 : 3));
            bif.i_ext_lock  = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd.gnt",   bif.o_gnt,       e_gnt);
            chk("rnd.done",  bif.o_done,      e_done);
            chk("rnd.err",   bif.o_err,       e_err);
            chk("rnd.rdata", bif.o_rdata,     e_rdata);
            chk("rnd.valid", bif.o_bus_valid, e_valid);
            chk("rnd.rw",    bif.o_bus_rw,    e_rw);
            chk("rnd.addr",  bif.o_bus_addr,  e_addr);
            chk("rnd.wdata", bif.o_bus_wdata, e_wdata);
            chk("rnd.lock",  bif.o_ext_lock,  e_lock);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 3: number of requesting masters, range 2..8.
REQ-002 Parameter ADDR_W, default 16: address width.
REQ-003 Parameter DATA_W, default 16: data width.
REQ-004 Parameter TIMEOUT, default 15: maximum ACCESS cycles before abort.
REQ-005 Parameter HOLD_MAX, default 31: maximum HOLD cycles before forced release.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 i_req  in  N_MASTERS  per-master request.
REQ-009 i_rw  in  N_MASTERS  per-master direction: 0 read, 1 write.
REQ-010 i_lock_req  in  N_MASTERS  per-master request to keep the bus after completion.
REQ-011 i_addr  in  N_MASTERS*ADDR_W  packed addresses; master k at bits [k*ADDR_W +: ADDR_W].
REQ-012 i_wdata  in  N_MASTERS*DATA_W  packed write data, same packing.
REQ-013 o_gnt  out  N_MASTERS  one-hot grant, or all zero.
REQ-014 o_done  out  N_MASTERS  one-cycle completion pulse.
REQ-015 o_err  out  N_MASTERS  one-cycle timeout pulse, coincident with o_done.
REQ-016 o_rdata  out  DATA_W  read data captured at completion.
REQ-017 o_bus_valid  out  1  external access in progress.
REQ-018 o_bus_rw  out  1  external direction; also the data-pad tristate enable at top level.
REQ-019 o_bus_addr  out  ADDR_W  external address.
REQ-020 o_bus_wdata  out  DATA_W  external write data.
REQ-021 i_bus_rdata  in  DATA_W  external read data.
REQ-022 i_bus_ready  in  1  external access complete.
REQ-023 i_ext_lock  in  1  bus locked by a foreign agent.
REQ-024 o_ext_lock  out  1  this arbiter holds the bus lock.

Function
REQ-025 The FSM SHALL have exactly three states: IDLE, ACCESS and HOLD.
REQ-026 In IDLE with i_ext_lock=0, eligible requests SHALL be arbitrated round-robin starting at ptr+1 mod N_MASTERS. A request is eligible when i_req=1 and o_done=0 for that master in the same cycle.
REQ-027 The winner SHALL be registered on the next edge: o_gnt one-hot, state ACCESS, o_bus_valid=1, and o_bus_addr/o_bus_wdata/o_bus_rw latched from the winner's inputs. Grant latency is 1 cycle.
REQ-028 In IDLE with i_ext_lock=1, no grant SHALL issue. i_ext_lock SHALL NOT affect ACCESS or HOLD.
REQ-029 In ACCESS, a timeout counter SHALL increment each cycle. On the edge where i_bus_ready=1, the block SHALL:
- assert o_done[winner] for one cycle;
- load o_rdata from i_bus_rdata if read (otherwise keep it);
- set ptr=winner;
- clear o_bus_valid.
REQ-030 If the counter reaches TIMEOUT with i_bus_ready=0, the block SHALL pulse o_done and o_err for the winner, leave o_rdata unchanged, and go to IDLE with o_gnt cleared. Ready arriving in the TIMEOUT cycle SHALL count as success.
REQ-031 On success with i_lock_req[winner]=1, the next state SHALL be HOLD: o_gnt kept, o_ext_lock=1. Otherwise the next state is IDLE with o_gnt=0.
REQ-032 In HOLD:
- i_req[holder]=1 with o_done=0 SHALL re-enter ACCESS with new latched payload and no arbitration.
- i_lock_req[holder]=0 SHALL release to IDLE.
- HOLD_MAX consecutive HOLD cycles SHALL force release to IDLE.
- Other masters SHALL NOT be granted.
REQ-033 o_ext_lock SHALL be 1 in HOLD and in any ACCESS entered from HOLD, and 0 otherwise.
REQ-034 Masters SHALL hold i_req and payload stable until o_done. Payload changes during ACCESS SHALL NOT alter the bus outputs.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL reset as follows, with rst taking priority over any in-flight access:
- state IDLE;
- o_gnt, o_done, o_err, o_bus_valid, o_bus_rw, o_ext_lock = 0;
- o_bus_addr, o_bus_wdata, o_rdata = 0;
- counters = 0;
- ptr = N_MASTERS-1, so master 0 wins first.

Structure
REQ-036 A shared package bus_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, HOLD=2) and default width constants.
REQ-037 A combinational sub-module rr_pick SHALL compute the one-hot winner from the request vector and ptr.

Verification
REQ-038 Reset, then i_req=3'b111 held -> grants in order 0,1,2,0 with ready after 2 cycles. One-cycle grant latency each time.
REQ-039 Master 1 read addr 0x1234, i_bus_rdata=0xBEEF with ready on the 3rd ACCESS cycle -> o_rdata=0xBEEF, o_done[1] exactly 1 cycle, o_err=0.
REQ-040 Ready never asserted -> o_done[0] and o_err[0] on the cycle after the 15th ACCESS cycle, then state IDLE.
REQ-041 Master 2 with i_lock_req=1 does two writes while master 0 requests -> o_ext_lock=1 throughout; master 0 is granted only after lock release.
REQ-042 i_ext_lock=1 with i_req=3'b001 -> no grant for 10 cycles; grant 1 cycle after i_ext_lock falls.
REQ-043 rst asserted mid-ACCESS -> all outputs 0 next cycle; first grant after reset goes to master 0.
